// File: rtl/systolic_driver_if.sv
// Signal bundle between the systolic-array job driver and its environment:
// command/status, three buffer ports and the array control/stream handshakes.
interface systolic_driver_if #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int COL_WIDTH = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int VEC_WIDTH = ARRAY_SIZE * DATA_WIDTH;
    localparam int RES_WIDTH = ARRAY_SIZE * ACC_WIDTH;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [15:0]           cmd_k;
    logic                  cmd_clear;
    logic [ADDR_WIDTH-1:0] cmd_wbase;
    logic [ADDR_WIDTH-1:0] cmd_abase;
    logic [ADDR_WIDTH-1:0] cmd_obase;

    logic                  busy;
    logic                  done;
    logic                  err;

    logic                  wgt_rd_en;
    logic [ADDR_WIDTH-1:0] wgt_rd_addr;
    logic [VEC_WIDTH-1:0]  wgt_rd_data;

    logic                  act_rd_en;
    logic [ADDR_WIDTH-1:0] act_rd_addr;
    logic [VEC_WIDTH-1:0]  act_rd_data;

    logic                  out_wr_en;
    logic [ADDR_WIDTH-1:0] out_wr_addr;
    logic [RES_WIDTH-1:0]  out_wr_data;

    logic                  start;
    logic                  clear_acc;
    logic [15:0]           cfg_k_tiles;
    logic                  weight_load_en;
    logic [COL_WIDTH-1:0]  weight_load_col;
    logic [VEC_WIDTH-1:0]  weight_load_data;

    logic                  act_valid;
    logic [VEC_WIDTH-1:0]  act_data;
    logic                  act_ready;

    logic                  result_valid;
    logic [RES_WIDTH-1:0]  result_data;
    logic                  result_ready;

    modport master (
        input  cmd_valid, cmd_k, cmd_clear, cmd_wbase, cmd_abase, cmd_obase,
        output cmd_ready, busy, done, err,
        output wgt_rd_en, wgt_rd_addr,
        input  wgt_rd_data,
        output act_rd_en, act_rd_addr,
        input  act_rd_data,
        output out_wr_en, out_wr_addr, out_wr_data,
        output start, clear_acc, cfg_k_tiles,
        output weight_load_en, weight_load_col, weight_load_data,
        output act_valid, act_data,
        input  act_ready,
        input  result_valid, result_data,
        output result_ready
    );

    modport slave (
        output cmd_valid, cmd_k, cmd_clear, cmd_wbase, cmd_abase, cmd_obase,
        input  cmd_ready, busy, done, err,
        input  wgt_rd_en, wgt_rd_addr,
        output wgt_rd_data,
        input  act_rd_en, act_rd_addr,
        output act_rd_data,
        input  out_wr_en, out_wr_addr, out_wr_data,
        input  start, clear_acc, cfg_k_tiles,
        input  weight_load_en, weight_load_col, weight_load_data,
        input  act_valid, act_data,
        output act_ready,
        output result_valid, result_data,
        input  result_ready
    );
endinterface

// File: rtl/systolic_driver.sv
// Job sequencer for a systolic array: loads weights, streams activation vectors,
// drains results to the output buffer, with a watchdog covering the array phase.
module systolic_driver #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1024
) (
    input logic               clk,
    input logic               rst_n,
    systolic_driver_if.master bus
);
    localparam int COL_WIDTH  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int VEC_WIDTH  = ARRAY_SIZE * DATA_WIDTH;
    localparam int RES_WIDTH  = ARRAY_SIZE * ACC_WIDTH;
    localparam int WCNT_WIDTH = $clog2(ARRAY_SIZE + 1);
    localparam int WD_WIDTH   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, START, STREAM, DRAIN, FIN} state_t;

    state_t                state_q, state_d;

    logic [15:0]           k_q;
    logic                  clear_q;
    logic [ADDR_WIDTH-1:0] wbase_q, abase_q, obase_q;
    logic                  err_q;

    logic [WCNT_WIDTH-1:0] wrd_cnt_q;
    logic                  wl_en_q;
    logic [COL_WIDTH-1:0]  wl_col_q;

    logic [15:0]           act_issued_q, act_accepted_q;
    logic                  act_valid_q, act_hold_sel_q;
    logic [VEC_WIDTH-1:0]  act_hold_q;

    logic [15:0]           res_cnt_q, wr_cnt_q;
    logic                  out_wr_en_q;
    logic [ADDR_WIDTH-1:0] out_wr_addr_q;
    logic [RES_WIDTH-1:0]  out_wr_data_q;

    logic [WD_WIDTH-1:0]   wd_cnt_q;

    logic                  cmd_fire, array_phase, timeout;
    logic                  wgt_rd_en, act_rd_en, act_fire, res_fire;
    logic                  act_valid_o, result_ready_o;
    logic [VEC_WIDTH-1:0]  act_data_o;
    logic                  last_wl, last_accept, writes_done;

    assign cmd_fire       = (state_q == IDLE) && bus.cmd_valid;
    assign array_phase    = (state_q == START) || (state_q == STREAM) || (state_q == DRAIN);
    assign timeout        = array_phase && (wd_cnt_q == WD_WIDTH'(TIMEOUT - 1));
    assign result_ready_o = array_phase;
    assign res_fire       = bus.result_valid && result_ready_o;

    assign wgt_rd_en = (state_q == LOAD_W) && (wrd_cnt_q < WCNT_WIDTH'(ARRAY_SIZE));
    assign last_wl   = wl_en_q && (wl_col_q == COL_WIDTH'(ARRAY_SIZE - 1));

    // The read data is presented the cycle it returns; if that beat stalls it
    // is parked in act_hold_q, so a new read is only issued into a free slot.
    assign act_valid_o = act_valid_q && (state_q == STREAM);
    assign act_data_o  = act_hold_sel_q ? act_hold_q : bus.act_rd_data;
    assign act_fire    = act_valid_o && bus.act_ready;
    assign act_rd_en   = (state_q == STREAM) && (act_issued_q < k_q) &&
                         (!act_valid_o || bus.act_ready);
    assign last_accept = act_fire && (act_accepted_q == k_q - 16'd1);

    // Count the write landing this cycle so DRAIN exits right after it.
    assign writes_done = (wr_cnt_q + 16'(out_wr_en_q)) >= 16'(ARRAY_SIZE);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = (bus.cmd_k == 16'd0) ? FIN : LOAD_W;
            LOAD_W:  if (last_wl) state_d = START;
            START:   state_d = STREAM;
            STREAM:  if (last_accept) state_d = DRAIN;
            DRAIN:   if (writes_done) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = FIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every register here, data included, is reset so that all outputs
    // read zero while rst_n is low and an abandoned job leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q            <= '0;
            clear_q        <= 1'b0;
            wbase_q        <= '0;
            abase_q        <= '0;
            obase_q        <= '0;
            err_q          <= 1'b0;
            wrd_cnt_q      <= '0;
            wl_en_q        <= 1'b0;
            wl_col_q       <= '0;
            act_issued_q   <= '0;
            act_accepted_q <= '0;
            act_valid_q    <= 1'b0;
            act_hold_sel_q <= 1'b0;
            act_hold_q     <= '0;
            res_cnt_q      <= '0;
            wr_cnt_q       <= '0;
            out_wr_en_q    <= 1'b0;
            out_wr_addr_q  <= '0;
            out_wr_data_q  <= '0;
            wd_cnt_q       <= '0;
        end else begin
            if (cmd_fire) begin
                k_q            <= bus.cmd_k;
                clear_q        <= bus.cmd_clear;
                wbase_q        <= bus.cmd_wbase;
                abase_q        <= bus.cmd_abase;
                obase_q        <= bus.cmd_obase;
                err_q          <= (bus.cmd_k == 16'd0);
                wrd_cnt_q      <= '0;
                act_issued_q   <= '0;
                act_accepted_q <= '0;
                act_valid_q    <= 1'b0;
                res_cnt_q      <= '0;
                wr_cnt_q       <= '0;
                wd_cnt_q       <= '0;
            end

            if (wgt_rd_en) wrd_cnt_q <= wrd_cnt_q + 1'b1;
            wl_en_q  <= wgt_rd_en;
            wl_col_q <= COL_WIDTH'(wrd_cnt_q);

            if (array_phase) wd_cnt_q <= wd_cnt_q + 1'b1;
            if (timeout) err_q <= 1'b1;

            if (act_rd_en) act_issued_q <= act_issued_q + 16'd1;
            if (act_fire) act_accepted_q <= act_accepted_q + 16'd1;
            if (act_rd_en) begin
                act_valid_q <= 1'b1;
            end else if (act_fire) begin
                act_valid_q <= 1'b0;
            end
            act_hold_sel_q <= act_valid_o && !bus.act_ready;
            if (act_valid_o) act_hold_q <= act_data_o;

            out_wr_en_q <= res_fire;
            if (res_fire) begin
                out_wr_addr_q <= obase_q + ADDR_WIDTH'(res_cnt_q);
                out_wr_data_q <= bus.result_data;
                res_cnt_q     <= res_cnt_q + 16'd1;
            end
            if (out_wr_en_q) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);
    assign bus.err       = (state_q == FIN) && err_q;

    assign bus.wgt_rd_en   = wgt_rd_en;
    assign bus.wgt_rd_addr = wgt_rd_en ? wbase_q + ADDR_WIDTH'(wrd_cnt_q) : '0;
    assign bus.act_rd_en   = act_rd_en;
    assign bus.act_rd_addr = act_rd_en ? abase_q + ADDR_WIDTH'(act_issued_q) : '0;

    assign bus.out_wr_en   = out_wr_en_q;
    assign bus.out_wr_addr = out_wr_addr_q;
    assign bus.out_wr_data = out_wr_data_q;

    assign bus.start       = (state_q == START);
    assign bus.clear_acc   = (state_q == START) && clear_q;
    assign bus.cfg_k_tiles = (array_phase || state_q == FIN) ? k_q : 16'd0;

    assign bus.weight_load_en   = wl_en_q;
    assign bus.weight_load_col  = wl_col_q;
    assign bus.weight_load_data = wl_en_q ? bus.wgt_rd_data : '0;

    assign bus.act_valid    = act_valid_o;
    assign bus.act_data     = act_valid_o ? act_data_o : '0;
    assign bus.result_ready = result_ready_o;
endmodule

// File: tb/tb_systolic_driver.sv
// Directed bench for systolic_driver: weight load, stalled activation stream,
// result drain, zero-length job, watchdog expiry and asynchronous reset.
module tb_systolic_driver;
    localparam int ARRAY_SIZE = 4;
    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int TIMEOUT    = 64;
    localparam int VW = ARRAY_SIZE * DATA_WIDTH;
    localparam int RW = ARRAY_SIZE * ACC_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_driver_if #(
        .ARRAY_SIZE(ARRAY_SIZE), .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH(ACC_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) bus ();

    systolic_driver #(
        .ARRAY_SIZE(ARRAY_SIZE), .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Buffer models: 1-cycle read latency, all-ones when not read so a
    // driver that fails to hold its data is exposed.
    logic [VW-1:0] wmem [64];
    logic [VW-1:0] amem [64];
    logic [RW-1:0] omem [64];

    always @(posedge clk) begin
        bus.wgt_rd_data <= bus.wgt_rd_en ? wmem[bus.wgt_rd_addr[5:0]] : '1;
        bus.act_rd_data <= bus.act_rd_en ? amem[bus.act_rd_addr[5:0]] : '1;
        if (bus.out_wr_en) omem[bus.out_wr_addr[5:0]] <= bus.out_wr_data;
    end

    int n_wgt_rd = 0;
    int n_act_rd = 0;
    int n_start  = 0;
    int n_done   = 0;
    int n_acc    = 0;
    logic [VW-1:0] acc_log [8];

    always @(negedge clk) begin
        if (bus.wgt_rd_en) n_wgt_rd++;
        if (bus.act_rd_en) n_act_rd++;
        if (bus.start) n_start++;
        if (bus.done) n_done++;
        if (bus.act_valid && bus.act_ready) begin
            if (n_acc < 8) acc_log[n_acc] = bus.act_data;
            n_acc++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] k, input logic clr, input logic [ADDR_WIDTH-1:0] wb,
                            input logic [ADDR_WIDTH-1:0] ab, input logic [ADDR_WIDTH-1:0] ob);
        bus.cmd_k     = k;
        bus.cmd_clear = clr;
        bus.cmd_wbase = wb;
        bus.cmd_abase = ab;
        bus.cmd_obase = ob;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        int w = 0;
        while (!bus.start && w < 20) begin
            tick();
            w++;
        end
        check("start_seen", bus.start, 1);
    endtask

    logic [RW-1:0] rvec [4];

    initial begin
        int snap_rd, snap_start, snap_done, n;

        bus.cmd_valid    = 1'b0;
        bus.cmd_k        = '0;
        bus.cmd_clear    = 1'b0;
        bus.cmd_wbase    = '0;
        bus.cmd_abase    = '0;
        bus.cmd_obase    = '0;
        bus.act_ready    = 1'b0;
        bus.result_valid = 1'b0;
        bus.result_data  = '0;
        for (int i = 0; i < 64; i++) begin
            wmem[i] = '0;
            amem[i] = '0;
            omem[i] = '0;
        end
        wmem[0] = 32'h0000_0001;
        wmem[1] = 32'h0000_0100;
        amem[8] = 32'h0000_0301;
        amem[9] = 32'h0000_0402;
        rvec[0] = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
        rvec[1] = 128'h0000_0014_0000_0013_0000_0012_0000_0011;
        rvec[2] = 128'hFFFF_FFFF_0000_0000_8000_0000_0000_0021;
        rvec[3] = 128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0;

        // Reset state
        #2;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_start", bus.start, 0);
        check("rst_act_valid", bus.act_valid, 0);
        check("rst_result_ready", bus.result_ready, 0);
        check("rst_out_wr_en", bus.out_wr_en, 0);
        check("rst_wl_en", bus.weight_load_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Job A: k=2, weights from 0, activations from 8, results to 16
        check("a_cmd_ready", bus.cmd_ready, 1);
        send_cmd(16'd2, 1'b1, 10'd0, 10'd8, 10'd16);
        check("a_busy", bus.busy, 1);
        check("a_cmd_ready_low", bus.cmd_ready, 0);
        check("a_wgt_rd_addr0", bus.wgt_rd_addr, 0);
        tick();
        for (int c = 0; c < 4; c++) begin
            check("a_wl_en", bus.weight_load_en, 1);
            check("a_wl_col", bus.weight_load_col, c);
            check("a_wl_data", bus.weight_load_data, wmem[c]);
            tick();
        end
        check("a_wl_en_off", bus.weight_load_en, 0);
        check("a_start", bus.start, 1);
        check("a_clear_acc", bus.clear_acc, 1);
        check("a_cfg_k", bus.cfg_k_tiles, 2);
        check("a_result_ready", bus.result_ready, 1);
        tick();
        check("a_start_once", bus.start, 0);
        check("a_act_valid_first", bus.act_valid, 0);
        check("a_act_rd_addr", bus.act_rd_addr, 8);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("a_act_stall_valid", bus.act_valid, 1);
            check("a_act_stall_data", bus.act_data, 32'h0301);
            tick();
        end
        bus.act_ready = 1'b1;
        check("a_act_beat0", bus.act_data, 32'h0301);
        tick();
        check("a_act_valid1", bus.act_valid, 1);
        check("a_act_beat1", bus.act_data, 32'h0402);
        bus.result_valid = 1'b1;
        bus.result_data  = rvec[0];
        tick();
        bus.act_ready = 1'b0;
        check("a_drain_act_valid", bus.act_valid, 0);
        check("a_drain_busy", bus.busy, 1);
        check("a_drain_result_ready", bus.result_ready, 1);
        for (int r = 1; r < 4; r++) begin
            check("a_wr_en", bus.out_wr_en, 1);
            check("a_wr_addr", bus.out_wr_addr, 16 + r - 1);
            check("a_wr_data", bus.out_wr_data, rvec[r-1]);
            bus.result_data = rvec[r];
            tick();
        end
        bus.result_valid = 1'b0;
        check("a_wr_addr_last", bus.out_wr_addr, 19);
        check("a_wr_data_last", bus.out_wr_data, rvec[3]);
        check("a_done_early", bus.done, 0);
        tick();
        check("a_done", bus.done, 1);
        check("a_err", bus.err, 0);
        check("a_fin_cfg_k", bus.cfg_k_tiles, 2);
        check("a_fin_result_ready", bus.result_ready, 0);
        tick();
        check("a_idle_busy", bus.busy, 0);
        check("a_idle_done", bus.done, 0);
        check("a_accept_count", n_acc, 2);
        check("a_accept0", acc_log[0], 32'h0301);
        check("a_accept1", acc_log[1], 32'h0402);
        for (int r = 0; r < 4; r++) check("a_omem", omem[16 + r], rvec[r]);

        // Job B: zero-length job
        snap_rd    = n_wgt_rd + n_act_rd;
        snap_start = n_start;
        send_cmd(16'd0, 1'b0, 10'd0, 10'd8, 10'd24);
        check("b_done", bus.done, 1);
        check("b_err", bus.err, 1);
        tick();
        check("b_busy_after", bus.busy, 0);
        check("b_no_reads", n_wgt_rd + n_act_rd, snap_rd);
        check("b_no_start", n_start, snap_start);

        // Job C: results never come back, watchdog fires
        bus.act_ready = 1'b1;
        send_cmd(16'd1, 1'b0, 10'd0, 10'd8, 10'd40);
        wait_start();
        n = 0;
        for (int i = 0; i < 200 && !bus.done; i++) begin
            tick();
            n++;
        end
        check("c_timeout_cycles", n, TIMEOUT);
        check("c_done", bus.done, 1);
        check("c_err", bus.err, 1);
        check("c_result_ready", bus.result_ready, 0);
        check("c_act_valid", bus.act_valid, 0);
        tick();
        check("c_result_ready_after", bus.result_ready, 0);
        check("c_busy_after", bus.busy, 0);

        // Job D: reset in the middle of the stream, then a fresh job
        bus.act_ready = 1'b0;
        send_cmd(16'd3, 1'b0, 10'd0, 10'd8, 10'd48);
        for (int i = 0; i < 30 && !bus.act_valid; i++) tick();
        check("d_streaming", bus.act_valid, 1);
        snap_done = n_done;
        #2 rst_n = 1'b0;
        #1;
        check("d_rst_act_valid", bus.act_valid, 0);
        check("d_rst_result_ready", bus.result_ready, 0);
        check("d_rst_busy", bus.busy, 0);
        check("d_rst_cmd_ready", bus.cmd_ready, 1);
        check("d_rst_cfg_k", bus.cfg_k_tiles, 0);
        check("d_rst_act_rd_en", bus.act_rd_en, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("d_no_done", n_done, snap_done);
        bus.act_ready = 1'b1;
        send_cmd(16'd1, 1'b0, 10'd0, 10'd9, 10'd32);
        wait_start();
        bus.result_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus.result_data = rvec[r];
            tick();
        end
        bus.result_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.done; i++) tick();
        check("d_done", bus.done, 1);
        check("d_err", bus.err, 0);
        for (int r = 0; r < 4; r++) check("d_omem", omem[32 + r], rvec[r]);
        check("d_accept_total", n_acc, 4);
        check("d_accept_last", acc_log[3], 32'h0402);
        tick();
        check("d_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench did not finish");
    end
endmodule

// File: doc/systolic_driver.md
SYSTOLIC_DRIVER -- requirements
Module: systolic_driver

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 4, PE rows/columns of the driven array.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, weight/activation element width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, result element width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 10, buffer address width.
REQ-005 SHALL have parameter TIMEOUT, default 1024, watchdog limit in cycles.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 cmd_valid / cmd_ready  in / out  1  command handshake.
REQ-009 cmd_k  in  16  activation vectors per job.
REQ-010 cmd_clear  in  1  clear accumulators at job start.
REQ-011 cmd_wbase, cmd_abase, cmd_obase  in  ADDR_WIDTH each  weight, activation and output base addresses.
REQ-012 busy, done, err  out  1  status; done and err are one-cycle pulses.
REQ-013 wgt_rd_en / wgt_rd_addr / wgt_rd_data  out / out / in  1 / ADDR_WIDTH / ARRAY_SIZE*DATA_WIDTH  weight buffer read port, 1-cycle latency.
REQ-014 act_rd_en / act_rd_addr / act_rd_data  out / out / in  1 / ADDR_WIDTH / ARRAY_SIZE*DATA_WIDTH  activation buffer read port, 1-cycle latency.
REQ-015 out_wr_en / out_wr_addr / out_wr_data  out / out / out  1 / ADDR_WIDTH / ARRAY_SIZE*ACC_WIDTH  output buffer write port.
REQ-016 start, clear_acc  out  1  array job-start pulse and accumulator clear.
REQ-017 cfg_k_tiles  out  16  array K count, held for the whole job.
REQ-018 weight_load_en / weight_load_col / weight_load_data  out / out / out  1 / clog2(ARRAY_SIZE) / ARRAY_SIZE*DATA_WIDTH  array weight load.
REQ-019 act_valid / act_data / act_ready  out / out / in  1 / ARRAY_SIZE*DATA_WIDTH / 1  activation stream handshake.
REQ-020 result_valid / result_data / result_ready  in / in / out  1 / ARRAY_SIZE*ACC_WIDTH / 1  result stream handshake.

Function
REQ-021 SHALL implement states IDLE, LOAD_W, START, STREAM, DRAIN, FIN.
REQ-022 IDLE: cmd_ready=1. On cmd_valid, SHALL latch all cmd_* fields. If cmd_k==0, go to FIN with err set. Otherwise go to LOAD_W.
REQ-023 LOAD_W: SHALL issue ARRAY_SIZE consecutive reads at wbase+c, c=0..ARRAY_SIZE-1.
REQ-024 LOAD_W output: each read SHALL be followed one cycle later by weight_load_en=1, col=c, data=wgt_rd_data; SHALL go to START after the last column is loaded.
REQ-025 START: SHALL drive start=1 and clear_acc=latched cmd_clear for exactly one cycle, then go to STREAM.
REQ-026 cfg_k_tiles SHALL equal latched cmd_k from START through FIN.
REQ-027 STREAM read issue: act read at abase+i SHALL be issued only when reads remain and (!act_valid || act_ready); at most one read outstanding.
REQ-028 STREAM output: read data SHALL load act_data with act_valid=1 on the next cycle, and be held stable until accepted (act_valid && act_ready).
REQ-029 STREAM throughput: with act_ready constantly high, SHALL sustain one vector per cycle.
REQ-030 STREAM exit: after exactly cmd_k vectors are accepted, SHALL go to DRAIN; act_valid SHALL then be 0.
REQ-031 result_ready SHALL be 1 from START through DRAIN, and 0 otherwise.
REQ-032 Each result handshake SHALL produce, one cycle later, out_wr_en=1, addr=obase+r, data=captured result_data; r increments per beat. Results arriving during STREAM are included.
REQ-033 DRAIN SHALL go to FIN after ARRAY_SIZE result beats have been written.
REQ-034 Watchdog: SHALL count cycles from START onward. If it reaches TIMEOUT before FIN, SHALL go to FIN with err; act_valid and result_ready SHALL drop immediately.
REQ-035 FIN: done=1 (and err if flagged) for one cycle, then IDLE.
REQ-036 busy SHALL be 1 in all states except IDLE.
REQ-037 A cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-038 rst_n low SHALL force IDLE immediately, regardless of current state.
REQ-039 Under reset, all outputs SHALL be 0 (including result_ready, act_valid, start, out_wr_en, done, err), except cmd_ready, which goes to 1 when IDLE is reached.
REQ-040 Under reset, counters and latched fields SHALL clear; an in-flight job is abandoned with no done pulse.

Verification
REQ-041 wmem[0..3]=0x01,0x0100,0,0; command wbase=0, k=2 -> weight_load_en high 4 consecutive cycles, col 0..3, data = wmem; then a single start pulse; cfg_k_tiles=2.
REQ-042 amem[8]=0x0301, amem[9]=0x0402, abase=8, act_ready forced low for 3 cycles after the first beat -> act_data held 0x0301; exactly two accepted beats, in order, no duplicates.
REQ-043 Array returns 4 result beats R0..R3, obase=16 -> out mem[16..19]=R0..R3; done pulses one cycle after the last write; busy then falls.
REQ-044 cmd_k=0 -> no buffer reads, no start; done and err pulse within 2 cycles.
REQ-045 Results never returned, TIMEOUT=64 -> done+err 64 cycles after start; result_ready=0 afterwards.
REQ-046 rst_n asserted mid-STREAM -> all outputs 0 asynchronously; after release a fresh command completes normally.
